// File: rtl/tx_frame_serializer_pkg.sv
// rtl/tx_frame_serializer_pkg.sv - shared constants and state type for the transmit serializer
package tx_pkg;

    localparam int FRAME_W = 96;
    localparam int SYM_W = 2;
    localparam int PRE_W = 16;
    localparam logic [PRE_W-1:0] PREAMBLE = 16'hA5F0;
    localparam int N_PRE_SYM = PRE_W / SYM_W;
    localparam int N_PAY_SYM = FRAME_W / SYM_W;

    // The sync word constant takes the bare name, so state literals carry an ST_ prefix.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD
    } tx_state_t;

endpackage

// File: rtl/tx_frame_serializer_dibit_mapper.sv
// rtl/tx_frame_serializer_dibit_mapper.sv - dibit constellation mapper, Gray coded when TX_GRAY_MAP_EN is defined
module dibit_mapper
    import tx_pkg::*;
(
    input  logic [SYM_W-1:0] raw,
    output logic [SYM_W-1:0] mapped
);

`ifdef TX_GRAY_MAP_EN
    assign mapped = raw ^ (raw >> 1);
`else
    assign mapped = raw;
`endif

endmodule

// File: rtl/tx_frame_serializer.sv
// rtl/tx_frame_serializer.sv - prepends the sync preamble to a frame and streams it as dibits (TX_GRAY_MAP_EN selects Gray mapping)
module tx_frame_serializer
    import tx_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [SYM_W-1:0]   sym_out,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               sym_last,
    output logic               busy
);

    localparam int TOT_W = PRE_W + FRAME_W;
    // The symbol on display lives in sym_out, so the shift register keeps only what follows it.
    localparam int REM_W = TOT_W - SYM_W;
    localparam int N_SYM = N_PRE_SYM + N_PAY_SYM;
    localparam int CNT_W = $clog2(N_SYM);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(N_PRE_SYM - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SYM - 1);

    tx_state_t state;
    tx_state_t state_nxt;

    logic [REM_W-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             xfer;
    logic             load;
    logic [SYM_W-1:0] map_in;
    logic [SYM_W-1:0] map_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    state_nxt = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (xfer && cnt == CNT_PRE_LAST) begin
                    state_nxt = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (xfer && sym_last) begin
                    state_nxt = load ? ST_PREAMBLE : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        frame_ready = 1'b0;
        load = 1'b0;
        xfer = sym_valid && sym_ready;
        if (!reset) begin
            frame_ready = (state == ST_IDLE) ||
                          (state == ST_PAYLOAD && sym_last && sym_ready);
        end
        load = frame_valid && frame_ready;
    end

    // On a load the first preamble dibit goes straight to the output register.
    assign map_in = load ? PREAMBLE[PRE_W-1 -: SYM_W] : sreg[REM_W-1 -: SYM_W];

    dibit_mapper u_mapper (
        .raw    (map_in),
        .mapped (map_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg      <= '0;
            cnt       <= '0;
            sym_out   <= '0;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            sreg      <= {PREAMBLE[PRE_W-SYM_W-1:0], frame_in};
            cnt       <= '0;
            sym_out   <= map_out;
            sym_valid <= 1'b1;
            sym_last  <= 1'b0;
            busy      <= 1'b1;
        end else if (xfer) begin
            if (sym_last) begin
                sreg      <= '0;
                cnt       <= '0;
                sym_out   <= '0;
                sym_valid <= 1'b0;
                sym_last  <= 1'b0;
                busy      <= 1'b0;
            end else begin
                sreg     <= {sreg[REM_W-SYM_W-1:0], {SYM_W{1'b0}}};
                cnt      <= cnt + CNT_W'(1);
                sym_out  <= map_out;
                sym_last <= (cnt + CNT_W'(1)) == CNT_LAST;
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_serializer.sv
// tb/tb_tx_frame_serializer.sv - directed self-checking bench for tx_frame_serializer
module tb_tx_frame_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic        sym_ready;
    logic        sym_last;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    logic [1:0] got [0:55];
    logic [1:0] hand_head [0:15];
    logic [1:0] hand_tail [0:1];

    localparam logic [95:0] F1 = 96'h0123_4567_89AB_CDEF_0011_2233;
    localparam logic [95:0] F_ONES = {96{1'b1}};
    localparam logic [95:0] F_ZERO = 96'h0;
    localparam logic [95:0] F_ALT = 96'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A;

    tx_frame_serializer dut (
        .clk         (clk),
        .reset       (reset),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sym_out     (sym_out),
        .sym_valid   (sym_valid),
        .sym_ready   (sym_ready),
        .sym_last    (sym_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] gray(input logic [1:0] d);
`ifdef TX_GRAY_MAP_EN
        return {d[1], d[1] ^ d[0]};
`else
        return d;
`endif
    endfunction

    function automatic logic [1:0] exp_sym(input logic [95:0] f, input int idx);
        logic [111:0] w;
        w = {16'hA5F0, f};
        return gray(w[111 - 2*idx -: 2]);
    endfunction

    // Entered one step after the accepting edge; returns one step after the last transfer edge.
    task automatic drain(input logic [95:0] f, input bit bp);
        int idx = 0;
        int cyc = 0;
        bit r;
        bit stalled = 1'b0;
        logic [1:0] prev = 2'b00;
        while (idx < 56 && cyc < 500) begin
            r = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            sym_ready = r;
            #1;
            chk("sym_valid", sym_valid, 1'b1);
            chk("sym_out", sym_out, exp_sym(f, idx));
            chk("sym_last", sym_last, idx == 55);
            chk("busy", busy, 1'b1);
            chk("frame_ready", frame_ready, r && idx == 55);
            if (stalled) chk("stall_hold", sym_out, prev);
            stalled = !r;
            prev = sym_out;
            if (r) begin
                got[idx] = sym_out;
                idx++;
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("drain_count", idx, 56);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, sym_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_last"}, sym_last, 1'b0);
        chk({tag, "_ready"}, frame_ready, 1'b1);
    endtask

    task automatic chk_hand(input string tag);
        for (int i = 0; i < 16; i++) chk({tag, "_head"}, got[i], hand_head[i]);
        chk({tag, "_tail54"}, got[54], hand_tail[0]);
        chk({tag, "_tail55"}, got[55], hand_tail[1]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef TX_GRAY_MAP_EN
        hand_head = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0,
                      2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd3, 2'd0, 2'd2};
        hand_tail = '{2'd0, 2'd2};
`else
        hand_head = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd3, 2'd3, 2'd0, 2'd0,
                      2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd3};
        hand_tail = '{2'd0, 2'd3};
`endif
        reset = 1'b1;
        frame_in = '0;
        frame_valid = 1'b0;
        sym_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", sym_valid, 1'b0);
        chk("rst_out", sym_out, 2'b00);
        chk("rst_last", sym_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_ready", frame_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("idle_frame_ready", frame_ready, 1'b1);

        // single frame, always ready; frame_in changes after accept must be ignored
        frame_in = F1;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        frame_in = 96'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
        drain(F1, 1'b0);
        chk_hand("single");
        chk_idle("single_end");

        // backpressure 1,0,0,1
        frame_in = F1;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        drain(F1, 1'b1);
        chk_hand("bp");
        chk_idle("bp_end");

        // back-to-back, second frame offered while first is in flight
        frame_in = F_ONES;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_in = F_ZERO;
        drain(F_ONES, 1'b0);
        frame_valid = 1'b0;
        chk("b2b_gap_valid", sym_valid, 1'b1);
        chk("b2b_gap_sym", sym_out, hand_head[0]);
        drain(F_ZERO, 1'b0);
        chk_idle("b2b_end");

        // reset after the 20th transfer
        frame_in = F1;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        sym_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_sym20", sym_out, exp_sym(F1, 20));
        reset = 1'b1;
        #1;
        chk("mid_rst_frame_ready", frame_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_valid", sym_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_last", sym_last, 1'b0);
        chk("mid_rst_out", sym_out, 2'b00);
        reset = 1'b0;
        frame_in = F_ALT;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        drain(F_ALT, 1'b0);
        for (int i = 0; i < 8; i++) chk("post_rst_pre", got[i], hand_head[i]);
        chk_idle("post_rst_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
